// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative radix-2 multiply / restoring divide with HI/LO registers.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation into {HI,LO}.
module ex_muldiv_unit #(
   parameter int NB_DATA  = 32,
   parameter int NB_MD_OP = 4
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [NB_MD_OP-1:0] i_op,
   input  logic [NB_DATA-1:0]  i_bus_a,
   input  logic [NB_DATA-1:0]  i_bus_b,
   input  logic                i_rd_hilo,
   input  logic                i_flush,
   output logic [NB_DATA-1:0]  o_hi,
   output logic [NB_DATA-1:0]  o_lo,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_stall
);
   localparam int NB_CNT = $clog2(NB_DATA);
   localparam logic [NB_MD_OP-1:0] OP_MULT  = NB_MD_OP'(0);
   localparam logic [NB_MD_OP-1:0] OP_MULTU = NB_MD_OP'(1);
   localparam logic [NB_MD_OP-1:0] OP_DIV   = NB_MD_OP'(2);
   localparam logic [NB_MD_OP-1:0] OP_DIVU  = NB_MD_OP'(3);
   localparam logic [NB_MD_OP-1:0] OP_MTHI  = NB_MD_OP'(4);
   localparam logic [NB_MD_OP-1:0] OP_MTLO  = NB_MD_OP'(5);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t state, state_next;

   logic [NB_CNT-1:0]    cnt;
   logic [2*NB_DATA-1:0] w, w_next, prod, hilo_fix;
   logic [NB_DATA-1:0]   m, hi, lo, a_abs, b_abs, quo, rem;
   logic [NB_DATA:0]     add_sum, rem_try, rem_diff;
   logic                 is_div, neg_p, neg_r, done, sa, sb;
   logic                 op_div, op_acc, op_sgn, op_go, accept;

`ifdef MULDIV_MADD_EN
   localparam logic [NB_MD_OP-1:0] OP_MADD  = NB_MD_OP'(6);
   localparam logic [NB_MD_OP-1:0] OP_MADDU = NB_MD_OP'(7);
   localparam logic [NB_MD_OP-1:0] OP_MSUB  = NB_MD_OP'(8);
   localparam logic [NB_MD_OP-1:0] OP_MSUBU = NB_MD_OP'(9);
   logic                 is_acc, is_sub;
   logic [2*NB_DATA-1:0] acc;
   assign op_acc = i_op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
   assign op_sgn = i_op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
`else
   assign op_acc = 1'b0;
   assign op_sgn = i_op inside {OP_MULT, OP_DIV};
`endif

   assign op_div = i_op inside {OP_DIV, OP_DIVU};
   assign op_go  = op_acc | op_div | (i_op inside {OP_MULT, OP_MULTU});
   assign accept = i_start & ~i_flush & (state == IDLE);
   assign sa     = op_sgn & i_bus_a[NB_DATA-1];
   assign sb     = op_sgn & i_bus_b[NB_DATA-1];
   assign a_abs  = sa ? -i_bus_a : i_bus_a;
   assign b_abs  = sb ? -i_bus_b : i_bus_b;

   // w holds {partial product, multiplier} or {remainder, dividend/quotient}
   assign add_sum  = {1'b0, w[2*NB_DATA-1:NB_DATA]} + (w[0] ? {1'b0, m} : '0);
   assign rem_try  = w[2*NB_DATA-1:NB_DATA-1];
   assign rem_diff = rem_try - {1'b0, m};
   assign w_next   = !is_div ? {add_sum, w[NB_DATA-1:1]} :
                     rem_diff[NB_DATA] ? {rem_try[NB_DATA-1:0], w[NB_DATA-2:0], 1'b0} :
                                         {rem_diff[NB_DATA-1:0], w[NB_DATA-2:0], 1'b1};

   assign prod = neg_p ? -w : w;
   assign quo  = neg_p ? -w[NB_DATA-1:0] : w[NB_DATA-1:0];
   assign rem  = neg_r ? -w[2*NB_DATA-1:NB_DATA] : w[2*NB_DATA-1:NB_DATA];
`ifdef MULDIV_MADD_EN
   assign acc      = is_sub ? {hi, lo} - prod : {hi, lo} + prod;
   assign hilo_fix = is_div ? {rem, quo} : is_acc ? acc : prod;
`else
   assign hilo_fix = is_div ? {rem, quo} : prod;
`endif

   always_comb begin
      state_next = state;
      state_next = state == IDLE ? ((accept && op_go) ? CALC : IDLE) :
                   i_flush       ? IDLE :
                   state == CALC ? ((cnt == '0) ? FIX : CALC) : IDLE;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) state <= IDLE;
      else          state <= state_next;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         done   <= 1'b0;
         w      <= '0;
         m      <= '0;
         is_div <= 1'b0;
         neg_p  <= 1'b0;
         neg_r  <= 1'b0;
`ifdef MULDIV_MADD_EN
         is_acc <= 1'b0;
         is_sub <= 1'b0;
`endif
      end else begin
         done <= (state == FIX) && !i_flush;
         if (accept && op_go) begin
            w      <= {{NB_DATA{1'b0}}, op_div ? a_abs : b_abs};
            m      <= op_div ? b_abs : a_abs;
            cnt    <= NB_CNT'(NB_DATA - 1);
            is_div <= op_div;
            // a zero divisor keeps the all-ones quotient unsigned
            neg_p  <= (sa ^ sb) & (~op_div | (|i_bus_b));
            neg_r  <= sa;
`ifdef MULDIV_MADD_EN
            is_acc <= op_acc;
            is_sub <= i_op inside {OP_MSUB, OP_MSUBU};
`endif
         end else if (accept && i_op == OP_MTHI) begin
            hi <= i_bus_a;
         end else if (accept && i_op == OP_MTLO) begin
            lo <= i_bus_a;
         end else if (state == CALC) begin
            w   <= w_next;
            cnt <= cnt - 1'b1;
         end else if (state == FIX && !i_flush) begin
            {hi, lo} <= hilo_fix;
         end
      end
   end

   assign o_hi    = hi;
   assign o_lo    = lo;
   assign o_busy  = state != IDLE;
   assign o_done  = done;
   assign o_stall = o_busy & (i_rd_hilo | i_start);
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed-vector bench for ex_muldiv_unit at NB_DATA = 32.
module tb_ex_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  op = '0;
   logic [31:0] bus_a = '0, bus_b = '0;
   logic        rd_hilo = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] hi, lo;
   logic        busy, done, stall;
   int          n_tests = 0, n_fail = 0;
   int          lat, n_done;
   logic [31:0] exp_hi, exp_lo;

   ex_muldiv_unit #(.NB_DATA(32), .NB_MD_OP(4)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_op(op),
      .i_bus_a(bus_a), .i_bus_b(bus_b), .i_rd_hilo(rd_hilo), .i_flush(flush),
      .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_done(done), .o_stall(stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // presents one request for a single edge, then counts busy cycles up to the done cycle
   task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int l);
      @(negedge clk);
      start = 1'b1; op = o; bus_a = a; bus_b = b;
      @(negedge clk);
      start = 1'b0;
      l = 0;
      while (busy && l < 100) begin
         l++;
         @(negedge clk);
      end
   endtask

   task automatic md_check(input string tag, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      int l;
      run_op(o, a, b, l);
      check({tag, "_lat"}, 64'(l), 64'd33);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_hi"}, 64'(hi), 64'(eh));
      check({tag, "_lo"}, 64'(lo), 64'(el));
      @(negedge clk);
      check({tag, "_done_off"}, 64'(done), 64'd0);
   endtask

   initial begin
      @(negedge clk);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      rst_n = 1'b1;

      md_check("mult", 4'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      md_check("multu", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      md_check("divu", 4'd3, 32'd100, 32'd7, 32'd2, 32'd14);
      md_check("div_neg", 4'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      md_check("div_negb", 4'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
      md_check("div_min", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
      md_check("div_zero", 4'd2, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
      md_check("divu_zero", 4'd3, 32'h8765_4321, 32'd0, 32'h8765_4321, 32'hFFFF_FFFF);

      // dependent reads and a second request while busy
      @(negedge clk);
      start = 1'b1; op = 4'd1; bus_a = 32'd6; bus_b = 32'd7;
      @(negedge clk);
      bus_a = 32'd2; bus_b = 32'd3; rd_hilo = 1'b1;
      lat = 0;
      while (busy && lat < 100) begin
         lat++;
         #1 check("stall_busy", 64'(stall), 64'd1);
         @(negedge clk);
      end
      start = 1'b0;
      #1;
      check("stall_lat", 64'(lat), 64'd33);
      check("stall_done_cycle", 64'(stall), 64'd0);
      check("stall_done", 64'(done), 64'd1);
      check("stall_hi", 64'(hi), 64'd0);
      check("stall_lo", 64'(lo), 64'd42);
      rd_hilo = 1'b0;
      repeat (3) @(negedge clk);
      check("stall_second_ignored", 64'(busy), 64'd0);
      check("stall_lo_kept", 64'(lo), 64'd42);

      // MTHI / MTLO then MADD
      @(negedge clk);
      start = 1'b1; op = 4'd4; bus_a = 32'h11;
      @(negedge clk);
      check("mthi", 64'(hi), 64'h11);
      check("mthi_busy", 64'(busy), 64'd0);
      op = 4'd5; bus_a = 32'h22;
      @(negedge clk);
      start = 1'b0;
      check("mtlo", 64'(lo), 64'h22);
      check("mtlo_done", 64'(done), 64'd0);
`ifdef MULDIV_MADD_EN
      md_check("madd", 4'd6, 32'd3, 32'd4, 32'h11, 32'h2E);
      exp_hi = 32'h11; exp_lo = 32'h2E;
`else
      @(negedge clk);
      start = 1'b1; op = 4'd6; bus_a = 32'd3; bus_b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      check("madd_off_busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("madd_off_hi", 64'(hi), 64'h11);
      check("madd_off_lo", 64'(lo), 64'h22);
      exp_hi = 32'h11; exp_lo = 32'h22;
`endif

      // flush at CALC cycle 10
      @(negedge clk);
      start = 1'b1; op = 4'd1; bus_a = 32'hFFFF; bus_b = 32'hFFFF;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_idle", 64'(busy), 64'd0);
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("flush_no_done", 64'(n_done), 64'd0);
      check("flush_hi", 64'(hi), 64'(exp_hi));
      check("flush_lo", 64'(lo), 64'(exp_lo));

      // flush in IDLE suppresses a same-cycle request
      start = 1'b1; op = 4'd4; bus_a = 32'h55; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_idle_mthi", 64'(hi), 64'(exp_hi));

      // asynchronous reset mid-CALC
      @(negedge clk);
      start = 1'b1; op = 4'd0; bus_a = 32'd9; bus_b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("areset_hi", 64'(hi), 64'd0);
      check("areset_lo", 64'(lo), 64'd0);
      check("areset_busy", 64'(busy), 64'd0);
      check("areset_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      md_check("post_reset", 4'd1, 32'd2, 32'd3, 32'd0, 32'd6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit for the execution stage, generalised over data width, with architectural HI/LO registers. It sits beside the single-cycle ALU in EX and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the ID/EX bus. It runs a radix-2 shift-add / restoring-divide loop over NB_DATA cycles. While busy, it stalls ID whenever a dependent HI/LO access or a second mul/div arrives.

## Interface
- NB_DATA, 32, operand and HI/LO width; any even value ≥ 8
- NB_MD_OP, 4, width of operation code
- i_clk  in  1  clock; all state updates on the rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  request; sampled with i_op/i_bus_a/i_bus_b
- i_op  in  NB_MD_OP  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; any other code is a no-op
- i_bus_a  in  NB_DATA  rs operand (multiplicand/dividend; MTHI/MTLO source)
- i_bus_b  in  NB_DATA  rt operand (multiplier/divisor)
- i_rd_hilo  in  1  ID holds an MFHI/MFLO this cycle
- i_flush  in  1  abort the in-flight operation
- o_hi  out  NB_DATA  HI register
- o_lo  out  NB_DATA  LO register
- o_busy  out  1  iterative operation in progress
- o_done  out  1  one-cycle pulse when HI/LO were just updated by mul/div
- o_stall  out  1  combinational: o_busy & (i_rd_hilo | i_start)

## Operation
- FSM states:
  - IDLE: accepts a request.
  - CALC: NB_DATA iterations, counter counting down from NB_DATA-1.
  - FIX: sign correction and accumulate, then writes HI/LO.
- IDLE + i_start + (MULT..DIVU, MADD..MSUBU) → CALC. Operands are latched. Signed ops take absolute values and record the result signs.
- IDLE + i_start + MTHI/MTLO: write i_bus_a to HI or LO at that edge and stay in IDLE. o_busy and o_done stay low.
- CALC, counter 0 → FIX; FIX → IDLE unconditionally.
- Multiply:
  - {HI,LO} = a·b, a 2·NB_DATA-bit product.
  - Signed ops negate the product when exactly one operand is negative.
  - MADD/MSUB: {HI,LO} ± product, modulo 2^(2·NB_DATA).
- Divide:
  - LO = quotient, HI = remainder, truncated toward zero; the remainder takes the sign of the dividend.
  - Divisor 0: LO = all ones, HI = dividend. Same latency.
  - Signed minimum ÷ −1: LO = minimum (0x80…0), HI = 0.
- i_start while o_busy is ignored; o_stall holds ID so the request is re-presented.
- i_flush in CALC/FIX → IDLE at the next edge; HI/LO unchanged, no o_done. i_flush in IDLE has no effect; it also suppresses a same-cycle i_start.
- Reset values: state IDLE, o_hi = 0, o_lo = 0, o_busy = 0, o_done = 0, counter = 0.

## Timing
- Request accepted at edge k.
- CALC occupies edges k+1 … k+NB_DATA.
- FIX at edge k+NB_DATA+1 writes HI/LO.
- o_busy is high for exactly NB_DATA+1 cycles, from after edge k until edge k+NB_DATA+1.
- o_done is high in the cycle after edge k+NB_DATA+1. New o_hi/o_lo are visible in that same cycle.
- A new request may be accepted at the edge that ends the o_done cycle, giving back-to-back throughput of NB_DATA+2 cycles.
- MFHI/MFLO in the o_done cycle reads the new value with no stall.
- MTHI/MTLO: 1-cycle latency, updated value visible after edge k.
- i_reset assertion mid-operation clears everything immediately (asynchronous). On release, the unit is in IDLE on the first edge.

## Configuration
- MULDIV_MADD_EN: defined → op codes 6–9 (MADD, MADDU, MSUB, MSUBU) accumulate into {HI,LO} during FIX.
- Not defined → op codes 6–9 are no-ops, accepted in IDLE with no state change. The accumulate adder is not synthesised.

## Test plan
- NB_DATA = 32, MULT a = 0xFFFFFFFD (−3), b = 5 → o_busy for 33 cycles, then o_done pulse; HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- DIVU 100 / 7 → LO = 14, HI = 2. DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIV 0x12345678 / 0 → LO = 0xFFFFFFFF, HI = 0x12345678, latency 33 cycles.
- Start MULTU, raise i_rd_hilo and a second i_start during busy → o_stall = 1 each busy cycle; the second request is ignored; HI/LO reflect only the first.
- MTHI 0x11, MTLO 0x22, then MADD 3 × 4 (macro defined) → HI = 0x11, LO = 0x2E. Macro undefined → HI/LO unchanged.
- Assert i_flush at CALC cycle 10 → IDLE next edge, no o_done, HI/LO keep prior values. Assert i_reset low mid-CALC → all outputs 0 immediately.
